quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CNT_W, default 4, position counter width in bits.
REQ-002 Parameter FILT, default 2, range 1-15, consecutive cycles a synchronized phase pair must hold before acceptance.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 qa  input  1  encoder phase A, asynchronous to clk.
REQ-006 qb  input  1  encoder phase B, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of cnt and err_flag, active-high.
REQ-008 cnt  output  CNT_W  position count, wraps modulo 2^CNT_W.
REQ-009 up_dnb  output  1  direction of last accepted step; 1 = up, 0 = down.
REQ-010 step  output  1  one-cycle pulse per accepted legal transition.
REQ-011 err  output  1  one-cycle pulse per illegal transition (both phases changed).
REQ-012 err_flag  output  1  sticky illegal-transition flag.

Function
REQ-013 qa and qb SHALL each pass through a two-flop synchronizer before any other use.
REQ-014 The filter SHALL accept a synchronized pair {qa,qb} only after it differs from the accepted state and stays constant for FILT consecutive clock edges; any change during that window restarts the window.
REQ-015 A clean input change held stable SHALL produce step/err high exactly in the cycle following clock edge FILT+3, counting the first edge that captures the new value as edge 1.
REQ-016 Up sequence of {qa,qb}: 00->10->11->01->00; each such accepted transition SHALL increment cnt by 1, set up_dnb=1, and pulse step.
REQ-017 Down sequence: reverse of REQ-016; each accepted transition SHALL decrement cnt by 1, set up_dnb=0, and pulse step.
REQ-018 Accepted transition with both bits changed (00<->11, 10<->01) SHALL pulse err, set err_flag, leave cnt and up_dnb unchanged, not pulse step, and update the accepted state to the new pair.
REQ-019 cnt SHALL wrap: all-ones +1 -> 0, 0 -1 -> all-ones, with no flag.
REQ-020 step and err SHALL never be high in the same cycle.
REQ-021 clr=1 SHALL set cnt=0 and err_flag=0 at the next edge; clr SHALL win over a step or err in the same cycle (count discarded, err_flag stays 0), while step/err pulses and up_dnb still follow REQ-016..018.
REQ-022 Direction reversal (e.g. 10->11->10) SHALL count +1 then -1 with up_dnb following each step.
REQ-023 States: INIT (after reset, no accepted state) and RUN; in INIT the first filtered pair SHALL load the accepted state with no step/err and move to RUN.

Reset
REQ-024 reset low SHALL immediately force cnt=0, up_dnb=1, step=0, err=0, err_flag=0, synchronizers and filter cleared, state INIT.
REQ-025 reset asserted mid-transition SHALL discard pending filter progress; after release the pair then present is loaded via INIT without counting.
REQ-026 reset release SHALL be synchronous to clk in effect; first edge after release is edge 1 of synchronization.

Verification
REQ-027 Reset release with qa=qb=0 held, FILT=2 -> no step/err; cnt=0, up_dnb=1.
REQ-028 From 00, drive 10,11,01,00,10 each held 8 cycles -> 5 step pulses, cnt=5, up_dnb=1, each step in cycle after edge 5.
REQ-029 From cnt=0 state 00, drive 01 held 8 cycles -> cnt=15, up_dnb=0, one step.
REQ-030 From 00, toggle qa for 1 cycle only (glitch shorter than FILT) -> no step, cnt unchanged.
REQ-031 From 00, drive 11 held 8 cycles -> one err pulse, err_flag=1, cnt unchanged; then clr 1 cycle -> err_flag=0, cnt=0.
REQ-032 Assert reset low during filter window of a pending 00->10 -> all outputs reset at once; after release with 10 held, no step, cnt=0.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B phases, debounces the pair, and
// tracks position/direction with step, illegal-transition and sticky error outputs.
module quad_decoder #(
  parameter int CNT_W = 4,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             up_dnb,
  output logic             step,
  output logic             err,
  output logic             err_flag
);

  localparam int FW = 4;
  localparam logic [FW-1:0]    FILT_V  = FILT[FW-1:0];
  localparam logic [FW-1:0]    FW_ONE  = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  // {qa,qb} pairs: sync1 is the metastability stage, sync2 the usable copy.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       vld_pipe_q;
  logic [1:0]       cand_q, cand_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [1:0]       acc_q, acc_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up_q, up_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             flag_q, flag_d;

  logic fire, both_chg, dir_up;

  // Filter: cand is the pair currently being timed, fcnt its saturating run length.
  // fcnt stays 0 until the synchronizer holds post-reset data.
  always_comb begin
    cand_d = cand_q;
    fcnt_d = fcnt_q;
    if (!vld_pipe_q[1]) begin
      fcnt_d = '0;
    end else if (sync2_q != cand_q || fcnt_q == '0) begin
      cand_d = sync2_q;
      fcnt_d = FW_ONE;
    end else if (fcnt_q != FILT_V) begin
      fcnt_d = fcnt_q + FW_ONE;
    end
  end

  assign fire     = (fcnt_q == FILT_V);
  assign both_chg = &(acc_q ^ cand_q);
  // Forward order 00->10->11->01: a change of A counts up when A==B beforehand.
  assign dir_up   = (acc_q[1] ^ cand_q[1]) ^ (acc_q[1] ^ acc_q[0]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    flag_d  = flag_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    if (fire) begin
      case (state_q)
        ST_INIT: begin
          acc_d   = cand_q;
          state_d = ST_RUN;
        end
        default: begin
          if (cand_q != acc_q) begin
            acc_d = cand_q;
            if (both_chg) begin
              err_d  = 1'b1;
              flag_d = 1'b1;
            end else begin
              step_d = 1'b1;
              up_d   = dir_up;
              cnt_d  = dir_up ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
            end
          end
        end
      endcase
    end
    // Clear overrides any count or error flag produced in the same cycle.
    if (clr) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      vld_pipe_q <= 2'b00;
      cand_q     <= 2'b00;
      fcnt_q     <= '0;
      acc_q      <= 2'b00;
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      up_q       <= 1'b1;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      sync1_q    <= {qa, qb};
      sync2_q    <= sync1_q;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      cand_q     <= cand_d;
      fcnt_q     <= fcnt_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      up_q       <= up_d;
      step_q     <= step_d;
      err_q      <= err_d;
      flag_q     <= flag_d;
    end
  end

  assign cnt      = cnt_q;
  assign up_dnb   = up_q;
  assign step     = step_q;
  assign err      = err_q;
  assign err_flag = flag_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized + directed bench for quad_decoder: a sliding-window reference model
// predicts each step/err pulse into a queue that a negedge monitor drains.
module tb_quad_decoder;
  localparam int CNT_W = 4;
  localparam int FILT  = 2;
  localparam int CMAX  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             qa = 1'b0, qb = 1'b0, clr = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic             up_dnb, step, err, err_flag;

  quad_decoder #(.CNT_W(CNT_W), .FILT(FILT)) dut (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .clr(clr),
    .cnt(cnt), .up_dnb(up_dnb), .step(step), .err(err), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    bit is_err;
    int cnt;
    bit up;
    bit flag;
  } ev_t;

  ev_t exp_q[$];
  int  hist[$];
  int  ecount;
  int  m_cnt, m_acc;
  bit  m_up, m_flag, m_init;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Position of a {qa,qb} pair along the forward sequence 00,10,11,01.
  function automatic int pos(input int v);
    case (v)
      0: return 0;
      2: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: a pair is accepted at edge e when the samples taken at
  // edges e-2-FILT .. e-3 are all identical (2 sync edges + FILT hold + 1 output edge).
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      hist.delete();
      exp_q.delete();
      ecount = 0;
      m_cnt = 0; m_up = 1'b1; m_flag = 1'b0; m_init = 1'b1; m_acc = 0;
    end else begin
      bit stable, is_ev, is_err;
      int v, d;
      ecount++;
      hist.push_back({30'd0, qa, qb});
      is_ev = 1'b0; is_err = 1'b0;
      if (ecount >= FILT + 3) begin
        v = hist[ecount-4];
        stable = 1'b1;
        for (int k = ecount - 3 - FILT; k <= ecount - 4; k++)
          if (hist[k] != v) stable = 1'b0;
        if (stable) begin
          if (m_init) begin
            m_acc = v;
            m_init = 1'b0;
          end else if (v != m_acc) begin
            d = (pos(v) - pos(m_acc) + 4) % 4;
            is_ev = 1'b1;
            if (d == 2) begin
              is_err = 1'b1;
              m_flag = 1'b1;
            end else begin
              m_up  = (d == 1);
              m_cnt = (m_cnt + ((d == 1) ? 1 : CMAX - 1)) % CMAX;
            end
            m_acc = v;
          end
        end
      end
      if (clr) begin
        m_cnt = 0;
        m_flag = 1'b0;
      end
      if (is_ev) exp_q.push_back('{ecount, is_err, m_cnt, m_up, m_flag});
    end
  end

  // Monitor: every pulse must match the next predicted event, including its edge.
  initial forever begin
    @(negedge clk);
    if (reset && (step || err)) begin
      chk("step_err_exclusive", int'(step && err), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        chk("pulse_edge", ecount, ev.edge_n);
        chk("pulse_is_err", int'(err), int'(ev.is_err));
        chk("pulse_cnt", int'(cnt), ev.cnt);
        chk("pulse_up_dnb", int'(up_dnb), int'(ev.up));
        chk("pulse_err_flag", int'(err_flag), int'(ev.flag));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic put(input int v, input int hold);
    {qa, qb} = v[1:0];
    cycles(hold);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cnt"}, int'(cnt), m_cnt);
    chk({tag, "_up"}, int'(up_dnb), int'(m_up));
    chk({tag, "_flag"}, int'(err_flag), int'(m_flag));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cnt"}, int'(cnt), 0);
    chk({tag, "_up"}, int'(up_dnb), 1);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_flag"}, int'(err_flag), 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset");
    cycles(3);
    reset = 1'b1;

    // Idle 00 after release: INIT load only.
    put(0, 10);
    check_reset_outputs("idle00");

    // Full forward cycle plus one.
    put(2, 8); put(3, 8); put(1, 8); put(0, 8); put(2, 8);
    chk("fwd_cnt", int'(cnt), 5);
    chk("fwd_up", int'(up_dnb), 1);

    // Back to 00, clear, then a down step wraps to all-ones.
    put(0, 8);
    pulse_clr();
    cycles(2);
    chk("clr_cnt", int'(cnt), 0);
    put(1, 8);
    chk("wrap_cnt", int'(cnt), CMAX - 1);
    chk("wrap_up", int'(up_dnb), 0);

    // Return to 00, then a one-cycle glitch on qa.
    put(0, 8);
    put(2, 1);
    put(0, 8);
    check_state("glitch");

    // Climb to cnt=4 at 00, then an illegal 00->11.
    put(2, 8); put(3, 8); put(1, 8); put(0, 8);
    put(3, 8);
    chk("illegal_cnt", int'(cnt), 4);
    chk("illegal_flag", int'(err_flag), 1);
    pulse_clr();
    cycles(2);
    chk("illegal_clr_cnt", int'(cnt), 0);
    chk("illegal_clr_flag", int'(err_flag), 0);

    // clr coincident with a step, then with an err.
    {qa, qb} = 2'b01; cycles(4); pulse_clr(); cycles(4);
    {qa, qb} = 2'b10; cycles(4); pulse_clr(); cycles(4);
    check_state("clr_coinc");

    // Direction reversal 10->11->10.
    put(3, 8);
    chk("rev_up_cnt", int'(cnt), 1);
    put(2, 8);
    chk("rev_dn_cnt", int'(cnt), 0);
    chk("rev_dn_up", int'(up_dnb), 0);

    // Build a nonzero count at 00, then reset inside a pending 00->10 window.
    put(3, 8); put(1, 8); put(0, 8);
    chk("pre_reset_cnt", int'(cnt), 3);
    {qa, qb} = 2'b10;
    cycles(2);
    reset = 1'b0;
    #1 check_reset_outputs("midreset");
    cycles(2);
    reset = 1'b1;
    cycles(10);
    check_reset_outputs("post_reset");
    put(3, 8);
    chk("post_reset_step_cnt", int'(cnt), 1);

    // Random phase: arbitrary pairs and holds, occasional clr.
    for (int i = 0; i < 250; i++) begin
      int v, hold;
      v = $urandom_range(0, 3);
      hold = $urandom_range(1, 7);
      {qa, qb} = v[1:0];
      if ($urandom_range(0, 15) == 0) begin
        pulse_clr();
        if (hold > 1) cycles(hold - 1);
      end else begin
        cycles(hold);
      end
    end
    cycles(12);
    check_state("final");
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
